// File: rtl/alien_march_ctrl_pkg.sv
// Shared definitions for the alien march controller: record field layout,
// sweep FSM state encoding and default playfield / motion constants.
package alien_march_ctrl_pkg;

    // Alien record layout
    localparam int REC_W     = 28;
    localparam int X_LSB     = 18;
    localparam int X_W       = 10;
    localparam int Y_LSB     = 8;
    localparam int Y_W       = 10;
    localparam int TYPE_LSB  = 6;
    localparam int TYPE_W    = 2;
    localparam int ALIVE_BIT = 5;
    localparam int TIMER_LSB = 0;
    localparam int TIMER_W   = 5;

    // Alien RAM address and alive counter widths
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 5;

    // Default geometry and motion
    localparam int DEF_NUM_ALIENS = 18;
    localparam int DEF_STEP_X     = 2;
    localparam int DEF_DROP_Y     = 8;
    localparam int DEF_X_MIN      = 8;
    localparam int DEF_X_MAX      = 600;
    localparam int DEF_Y_LAND     = 400;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CALC,
        WR_REQ,
        WR_WAIT,
        NEXT,
        EVAL
    } march_state_t;

endpackage

// File: rtl/alien_march_ctrl_if.sv
// Game-port bus between the march controller (master) and the alien RAM (slave).
interface alien_march_ctrl_if;
    import alien_march_ctrl_pkg::*;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr_en;
    logic [REC_W-1:0]  ram_wr_data;
    logic [REC_W-1:0]  ram_rd_data;
    logic              ram_write_busy;

    modport master (
        output ram_addr,
        output ram_wr_en,
        output ram_wr_data,
        input  ram_rd_data,
        input  ram_write_busy
    );

    modport slave (
        input  ram_addr,
        input  ram_wr_en,
        input  ram_wr_data,
        output ram_rd_data,
        output ram_write_busy
    );
endinterface

// File: rtl/alien_march_ctrl_rec_update.sv
// alien_rec_update: purely combinational per-record step. Moves one alien
// (horizontal step or vertical drop), ages the explosion timer of dead aliens
// and flags playfield edge / landing hits for alive aliens using new values.
module alien_rec_update
    import alien_march_ctrl_pkg::*;
#(
    parameter int DROP_Y = DEF_DROP_Y,
    parameter int X_MIN  = DEF_X_MIN,
    parameter int X_MAX  = DEF_X_MAX,
    parameter int Y_LAND = DEF_Y_LAND
) (
    input  logic [REC_W-1:0] rec_in,
    input  logic             dir_left,
    input  logic             drop,
    input  logic [X_W-1:0]   step_x,
    output logic [REC_W-1:0] rec_out,
    output logic             is_alive,
    output logic             edge_hit,
    output logic             land_hit
);

    logic [X_W-1:0]     x_old, x_new;
    logic [Y_W-1:0]     y_old, y_new;
    logic [TIMER_W-1:0] timer_old, timer_new;
    logic               alive;

    // Field extraction, motion, timer ageing and hit detection for one record
    always_comb begin
        x_old     = rec_in[X_LSB +: X_W];
        y_old     = rec_in[Y_LSB +: Y_W];
        timer_old = rec_in[TIMER_LSB +: TIMER_W];
        alive     = rec_in[ALIVE_BIT];

        x_new = x_old;
        y_new = y_old;
        if (drop) begin
            y_new = y_old + Y_W'(DROP_Y);
        end else if (dir_left) begin
            x_new = x_old - step_x;
        end else begin
            x_new = x_old + step_x;
        end

        timer_new = timer_old;
        if (!alive && (timer_old != '0)) begin
            timer_new = timer_old - TIMER_W'(1);
        end

        // Type and alive pass through untouched
        rec_out                          = rec_in;
        rec_out[X_LSB +: X_W]            = x_new;
        rec_out[Y_LSB +: Y_W]            = y_new;
        rec_out[TIMER_LSB +: TIMER_W]    = timer_new;

        is_alive = alive;
        edge_hit = alive && ((x_new <= X_W'(X_MIN)) || (x_new >= X_W'(X_MAX)));
        land_hit = alive && (y_new >= Y_W'(Y_LAND));
    end

endmodule

// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: on each accepted move_tick, sweeps every alien record
// through read -> update -> write on the alien RAM game port, then evaluates
// the sweep (direction change, drop scheduling, invasion / extinction flags).
// Optional build macro: ALIEN_MARCH_SPEEDUP_EN doubles the horizontal step
// once the alive count of the last sweep falls to a third of the formation.
module alien_march_ctrl
    import alien_march_ctrl_pkg::*;
#(
    parameter int NUM_ALIENS = DEF_NUM_ALIENS,
    parameter int STEP_X     = DEF_STEP_X,
    parameter int DROP_Y     = DEF_DROP_Y,
    parameter int X_MIN      = DEF_X_MIN,
    parameter int X_MAX      = DEF_X_MAX,
    parameter int Y_LAND     = DEF_Y_LAND
) (
    input  logic                  game_clk,
    input  logic                  reset,
    input  logic                  move_tick,
    alien_march_ctrl_if.master    ram,
    output logic                  sweep_busy,
    output logic                  sweep_done,
    output logic                  tick_dropped,
    output logic                  dir_left,
    output logic [CNT_W-1:0]      alive_count,
    output logic                  invaded,
    output logic                  all_dead
);

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_ALIENS - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(NUM_ALIENS);

    march_state_t      state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [REC_W-1:0]  wr_data_q, wr_data_d;
    logic              dir_left_q, dir_left_d;
    logic              drop_pending_q, drop_pending_d;
    logic [CNT_W-1:0]  alive_count_q, alive_count_d;
    logic              invaded_q, invaded_d;
    logic              all_dead_q, all_dead_d;
    logic [CNT_W-1:0]  alive_acc_q, alive_acc_d;
    logic              edge_acc_q, edge_acc_d;
    logic              land_acc_q, land_acc_d;
    logic              seen_busy_q, seen_busy_d;

    logic [X_W-1:0]    step_cur;
    logic [REC_W-1:0]  upd_rec;
    logic              upd_alive, upd_edge, upd_land;

`ifdef ALIEN_MARCH_SPEEDUP_EN
    localparam logic [X_W-1:0]   STEP_SLOW  = X_W'(STEP_X);
    localparam logic [X_W-1:0]   STEP_FAST  = X_W'(2 * STEP_X);
    localparam logic [CNT_W-1:0] FAST_LIMIT = CNT_W'(NUM_ALIENS / 3);
    logic [X_W-1:0] step_q, step_d;
    assign step_cur = step_q;
`else
    assign step_cur = X_W'(STEP_X);
`endif

    alien_rec_update #(
        .DROP_Y (DROP_Y),
        .X_MIN  (X_MIN),
        .X_MAX  (X_MAX),
        .Y_LAND (Y_LAND)
    ) u_rec_update (
        .rec_in   (ram.ram_rd_data),
        .dir_left (dir_left_q),
        .drop     (drop_pending_q),
        .step_x   (step_cur),
        .rec_out  (upd_rec),
        .is_alive (upd_alive),
        .edge_hit (upd_edge),
        .land_hit (upd_land)
    );

    // Sweep sequencing: next-state and next-output computation
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        addr_d         = addr_q;
        wr_en_d        = 1'b0;
        wr_data_d      = wr_data_q;
        dir_left_d     = dir_left_q;
        drop_pending_d = drop_pending_q;
        alive_count_d  = alive_count_q;
        invaded_d      = invaded_q;
        all_dead_d     = all_dead_q;
        alive_acc_d    = alive_acc_q;
        edge_acc_d     = edge_acc_q;
        land_acc_d     = land_acc_q;
        seen_busy_d    = seen_busy_q;
`ifdef ALIEN_MARCH_SPEEDUP_EN
        step_d         = step_q;
`endif

        case (state_q)
            IDLE: begin
                // A halted game (invaded or wiped out) ignores ticks entirely
                if (move_tick && !invaded_q && !all_dead_q) begin
                    idx_d       = '0;
                    addr_d      = '0;
                    alive_acc_d = '0;
                    edge_acc_d  = 1'b0;
                    land_acc_d  = 1'b0;
`ifdef ALIEN_MARCH_SPEEDUP_EN
                    step_d      = (alive_count_q <= FAST_LIMIT) ? STEP_FAST : STEP_SLOW;
`endif
                    state_d     = RD_REQ;
                end
            end
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: state_d = CALC;
            CALC: begin
                wr_data_d  = upd_rec;
                if (upd_alive) begin
                    alive_acc_d = alive_acc_q + CNT_W'(1);
                end
                edge_acc_d = edge_acc_q | upd_edge;
                land_acc_d = land_acc_q | upd_land;
                state_d    = WR_REQ;
            end
            WR_REQ: begin
                if (!ram.ram_write_busy) begin
                    wr_en_d     = 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = WR_WAIT;
                end
            end
            WR_WAIT: begin
                // Address/data stay registered until the RAM has gone busy and idle again
                if (ram.ram_write_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + ADDR_W'(1);
                    addr_d  = idx_q + ADDR_W'(1);
                    state_d = RD_REQ;
                end else begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                alive_count_d = alive_acc_q;
                if (drop_pending_q) begin
                    drop_pending_d = 1'b0;
                    dir_left_d     = ~dir_left_q;
                end else if (edge_acc_q) begin
                    drop_pending_d = 1'b1;
                end
                if (land_acc_q) begin
                    invaded_d = 1'b1;
                end
                if (alive_acc_q == '0) begin
                    all_dead_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge game_clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            addr_q         <= '0;
            wr_en_q        <= 1'b0;
            wr_data_q      <= '0;
            dir_left_q     <= 1'b0;
            drop_pending_q <= 1'b0;
            alive_count_q  <= FULL_COUNT;
            invaded_q      <= 1'b0;
            all_dead_q     <= 1'b0;
            alive_acc_q    <= '0;
            edge_acc_q     <= 1'b0;
            land_acc_q     <= 1'b0;
            seen_busy_q    <= 1'b0;
`ifdef ALIEN_MARCH_SPEEDUP_EN
            step_q         <= STEP_SLOW;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            addr_q         <= addr_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            dir_left_q     <= dir_left_d;
            drop_pending_q <= drop_pending_d;
            alive_count_q  <= alive_count_d;
            invaded_q      <= invaded_d;
            all_dead_q     <= all_dead_d;
            alive_acc_q    <= alive_acc_d;
            edge_acc_q     <= edge_acc_d;
            land_acc_q     <= land_acc_d;
            seen_busy_q    <= seen_busy_d;
`ifdef ALIEN_MARCH_SPEEDUP_EN
            step_q         <= step_d;
`endif
        end
    end

    assign ram.ram_addr    = addr_q;
    assign ram.ram_wr_en   = wr_en_q;
    assign ram.ram_wr_data = wr_data_q;

    // Status decodes straight from the state register
    assign sweep_busy   = (state_q != IDLE);
    assign sweep_done   = (state_q == EVAL);
    assign tick_dropped = move_tick && (state_q != IDLE);

    assign dir_left    = dir_left_q;
    assign alive_count = alive_count_q;
    assign invaded     = invaded_q;
    assign all_dead    = all_dead_q;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Self-checking bench for alien_march_ctrl: alien RAM model with a write-busy
// window, formation-level reference model, per-cycle compare process and
// directed plus randomized tick scenarios.
`timescale 1ns/1ps
module tb_alien_march_ctrl;

    localparam int N     = 18;
    localparam int STEP  = 2;
    localparam int DROP  = 8;
    localparam int XMIN  = 8;
    localparam int XMAX  = 600;
    localparam int YLAND = 400;

    logic       game_clk = 1'b0;
    logic       reset = 1'b1;
    logic       move_tick = 1'b0;
    logic       sweep_busy, sweep_done, tick_dropped, dir_left, invaded, all_dead;
    logic [4:0] alive_count;

    alien_march_ctrl_if bus();

    alien_march_ctrl #(
        .NUM_ALIENS (N),
        .STEP_X     (STEP),
        .DROP_Y     (DROP),
        .X_MIN      (XMIN),
        .X_MAX      (XMAX),
        .Y_LAND     (YLAND)
    ) dut (
        .game_clk     (game_clk),
        .reset        (reset),
        .move_tick    (move_tick),
        .ram          (bus),
        .sweep_busy   (sweep_busy),
        .sweep_done   (sweep_done),
        .tick_dropped (tick_dropped),
        .dir_left     (dir_left),
        .alive_count  (alive_count),
        .invaded      (invaded),
        .all_dead     (all_dead)
    );

    always #5 game_clk = ~game_clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [27:0] mk_rec(input int x, input int y, input int typ, input int alive, input int timer);
        return {10'(x), 10'(y), 2'(typ), 1'(alive), 5'(timer)};
    endfunction
    function automatic int fx(input logic [27:0] r);  return int'(r[27:18]); endfunction
    function automatic int fy(input logic [27:0] r);  return int'(r[17:8]);  endfunction
    function automatic int fty(input logic [27:0] r); return int'(r[7:6]);   endfunction
    function automatic int fal(input logic [27:0] r); return int'(r[5]);     endfunction
    function automatic int ftm(input logic [27:0] r); return int'(r[4:0]);   endfunction

    // ---------------- alien RAM model ----------------
    logic [27:0] init_mem [0:31];
    logic [27:0] mem      [0:31];
    logic [27:0] rd_pipe;
    int          busy_cnt = 0;
    int          busy_len = 5;

    always @(posedge game_clk) begin
        rd_pipe         <= mem[bus.ram_addr];
        bus.ram_rd_data <= rd_pipe;
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
            busy_cnt <= 0;
        end else if (bus.ram_wr_en) begin
            mem[bus.ram_addr] <= bus.ram_wr_data;
            busy_cnt          <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign bus.ram_write_busy = (busy_cnt != 0);

    // ---------------- reference model ----------------
    logic [27:0] ref_mem [0:31];
    logic [27:0] exp_mem [0:31];
    int          ref_cnt = N;
    bit          ref_dir = 0, ref_drop = 0, ref_inv = 0, ref_dead = 0;
    int          exp_acc;
    bit          exp_edge, exp_land;
    bit          exp_busy = 0;
    int          wr_idx = 0, hold = 0, wr_total = 0, done_cnt = 0, drop_cnt = 0;
    logic [4:0]  hold_addr;
    logic [27:0] hold_data;
    bit          rst_prev = 0;

    // Whole-formation result of one sweep from the current reference state
    task automatic model_sweep();
        int step, x, y, t;
        step = STEP;
`ifdef ALIEN_MARCH_SPEEDUP_EN
        if (ref_cnt <= N / 3) step = 2 * STEP;
`endif
        exp_acc = 0; exp_edge = 0; exp_land = 0;
        for (int i = 0; i < N; i++) begin
            x = fx(ref_mem[i]); y = fy(ref_mem[i]); t = ftm(ref_mem[i]);
            if (ref_drop)     y = (y + DROP) % 1024;
            else if (ref_dir) x = (x - step + 1024) % 1024;
            else              x = (x + step) % 1024;
            if (fal(ref_mem[i]) == 0 && t != 0) t = t - 1;
            if (fal(ref_mem[i]) == 1) begin
                exp_acc++;
                if (x <= XMIN || x >= XMAX) exp_edge = 1;
                if (y >= YLAND) exp_land = 1;
            end
            exp_mem[i] = mk_rec(x, y, fty(ref_mem[i]), fal(ref_mem[i]), t);
        end
    endtask

    // Per-cycle compare of DUT outputs against the reference model
    always @(negedge game_clk) begin
        bit busy_next;
        if (reset) begin
            if (rst_prev) begin
                chk("rst_wr_en", bus.ram_wr_en, 0);
                chk("rst_addr", bus.ram_addr, 0);
                chk("rst_wr_data", bus.ram_wr_data, 0);
                chk("rst_busy", sweep_busy, 0);
                chk("rst_done", sweep_done, 0);
                chk("rst_dropped", tick_dropped, 0);
                chk("rst_dir", dir_left, 0);
                chk("rst_alive_count", alive_count, N);
                chk("rst_invaded", invaded, 0);
                chk("rst_all_dead", all_dead, 0);
            end
            ref_dir = 0; ref_drop = 0; ref_inv = 0; ref_dead = 0; ref_cnt = N;
            exp_busy = 0; hold = 0; wr_idx = 0; wr_total = 0; done_cnt = 0; drop_cnt = 0;
            for (int i = 0; i < 32; i++) ref_mem[i] = init_mem[i];
            rst_prev = 1;
        end else begin
            rst_prev  = 0;
            busy_next = exp_busy;
            chk("sweep_busy", sweep_busy, exp_busy);
            chk("tick_dropped", tick_dropped, move_tick && exp_busy);
            chk("done_outside_sweep", sweep_done && !exp_busy, 0);
            chk("dir_left", dir_left, ref_dir);
            chk("alive_count", alive_count, ref_cnt);
            chk("invaded", invaded, ref_inv);
            chk("all_dead", all_dead, ref_dead);
            if (tick_dropped) drop_cnt++;

            if (bus.ram_wr_en) begin
                wr_total++;
                chk("wr_in_sweep", exp_busy, 1);
                chk("wr_overlap", hold, 0);
                chk("wr_addr", bus.ram_addr, wr_idx);
                if (wr_idx < N) chk("wr_data", bus.ram_wr_data, exp_mem[wr_idx]);
                wr_idx++;
                hold = 1; hold_addr = bus.ram_addr; hold_data = bus.ram_wr_data;
            end else if (hold != 0) begin
                chk("hold_addr", bus.ram_addr, hold_addr);
                chk("hold_data", bus.ram_wr_data, hold_data);
                if (hold == 1 && bus.ram_write_busy) hold = 2;
                else if (hold == 2 && !bus.ram_write_busy) hold = 0;
            end

            if (sweep_done && exp_busy) begin
                done_cnt++;
                chk("writes_per_sweep", wr_idx, N);
                chk("write_window_closed", hold, 0);
                for (int i = 0; i < N; i++) chk("ram_record", mem[i], exp_mem[i]);
                for (int i = 0; i < N; i++) ref_mem[i] = exp_mem[i];
                ref_cnt = exp_acc;
                if (ref_drop) begin ref_drop = 0; ref_dir = !ref_dir; end
                else if (exp_edge) ref_drop = 1;
                if (exp_land) ref_inv = 1;
                if (exp_acc == 0) ref_dead = 1;
                busy_next = 0;
            end else if (move_tick && !exp_busy && !ref_inv && !ref_dead) begin
                model_sweep();
                wr_idx = 0;
                busy_next = 1;
            end
            exp_busy = busy_next;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge game_clk); #1 reset = 1'b1;
        repeat (3) @(posedge game_clk);
        #1 reset = 1'b0;
    endtask

    task automatic tick_pulse();
        @(posedge game_clk); #1 move_tick = 1'b1;
        @(posedge game_clk); #1 move_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_busy && n < 3000) begin
            @(posedge game_clk); #1;
            n++;
        end
        vectors++;
        if (exp_busy) begin
            errors++;
            $display("FAIL sweep_timeout: sweep still running after %0d cycles, required completion", n);
        end
    endtask

    task automatic sweep();
        tick_pulse();
        wait_idle();
    endtask

    task automatic form_default();
        for (int i = 0; i < 32; i++)
            init_mem[i] = (i < N) ? mk_rec(50 + 32 * (i % 6), 50 + 16 * (i / 6), i % 4, 1, 0) : 28'd0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int d0, k;
        busy_len = 5;
        form_default();
        repeat (3) @(posedge game_clk);
        #1 reset = 1'b0;

        // Default formation, one tick
        chk("post_rst_addr", bus.ram_addr, 0);
        chk("post_rst_alive", alive_count, 18);
        sweep();
        chk("s1_a0_x", fx(mem[0]), 52);
        chk("s1_a0_y", fy(mem[0]), 50);
        chk("s1_alive_count", alive_count, 18);
        chk("s1_done_cnt", done_cnt, 1);
        chk("s1_wr_total", wr_total, 18);

        // Edge hit, drop sweep, march back
        form_default();
        init_mem[5] = mk_rec(598, 50, 1, 1, 0);
        do_reset();
        sweep();
        chk("s2_a5_x", fx(mem[5]), 600);
        chk("s2_dir_before_drop", dir_left, 0);
        sweep();
        chk("s2_a5_x_drop", fx(mem[5]), 600);
        chk("s2_a5_y_drop", fy(mem[5]), 58);
        chk("s2_a0_x_drop", fx(mem[0]), 52);
        chk("s2_a17_y_drop", fy(mem[17]), 90);
        chk("s2_dir_after_drop", dir_left, 1);
        sweep();
        chk("s2_a5_x_back", fx(mem[5]), 598);
        chk("s2_a0_x_back", fx(mem[0]), 50);

        // Explosion timers on dead aliens
        busy_len = 1;
        form_default();
        init_mem[3] = mk_rec(146, 50, 3, 0, 3);
        init_mem[4] = mk_rec(178, 50, 0, 0, 0);
        do_reset();
        sweep();
        chk("s3_a3_timer", ftm(mem[3]), 2);
        chk("s3_a3_x", fx(mem[3]), 148);
        chk("s3_a4_timer", ftm(mem[4]), 0);
        chk("s3_alive_count", alive_count, 16);

        // Dropped tick mid-sweep, then invasion halts the march
        busy_len = 5;
        form_default();
        init_mem[5] = mk_rec(598, 50, 1, 1, 0);
        init_mem[0] = mk_rec(50, 396, 0, 1, 0);
        do_reset();
        tick_pulse();
        repeat (40) @(posedge game_clk);
        tick_pulse();
        wait_idle();
        chk("s4_drop_cnt", drop_cnt, 1);
        chk("s4_done_cnt", done_cnt, 1);
        chk("s4_not_invaded_yet", invaded, 0);
        sweep();
        chk("s4_invaded", invaded, 1);
        chk("s4_a0_y", fy(mem[0]), 404);
        sweep();
        repeat (20) @(posedge game_clk);
        #1;
        chk("s4_halted_done_cnt", done_cnt, 2);
        chk("s4_halted_busy", sweep_busy, 0);

        // Speedup threshold: 6 alive of 18
        busy_len = 2;
        for (int i = 0; i < 32; i++)
            init_mem[i] = (i < N) ? mk_rec(100 + 20 * (i % 6), 60, 0, (i < 6) ? 1 : 0, 0) : 28'd0;
        do_reset();
        sweep();
        chk("s5_first_step", fx(mem[0]), 102);
        chk("s5_alive_count", alive_count, 6);
        sweep();
`ifdef ALIEN_MARCH_SPEEDUP_EN
        chk("s5_second_step", fx(mem[0]), 106);
`else
        chk("s5_second_step", fx(mem[0]), 104);
`endif

        // Reset in the middle of a sweep abandons it
        form_default();
        do_reset();
        tick_pulse();
        repeat (30) @(posedge game_clk);
        do_reset();
        repeat (50) @(posedge game_clk);
        #1;
        chk("s6_no_writes_after_rst", wr_total, 0);
        chk("s6_idle_after_rst", sweep_busy, 0);

        // Wiped-out formation
        for (int i = 0; i < 32; i++) init_mem[i] = (i < N) ? mk_rec(200, 100, 1, 0, i) : 28'd0;
        do_reset();
        sweep();
        chk("s7_all_dead", all_dead, 1);
        chk("s7_alive_count", alive_count, 0);
        d0 = done_cnt;
        sweep();
        chk("s7_halted", done_cnt, d0);

        // Randomized formations, busy windows and tick timing
        for (int r = 0; r < 4; r++) begin
            busy_len = $urandom_range(1, 5);
            for (int i = 0; i < 32; i++)
                init_mem[i] = (i < N) ? mk_rec($urandom_range(0, 1023), $urandom_range(0, 420), $urandom_range(0, 3),
                                               ($urandom_range(0, 9) < 7) ? 1 : 0, $urandom_range(0, 31)) : 28'd0;
            do_reset();
            for (int t = 0; t < 8; t++) begin
                k = $urandom_range(0, 10);
                repeat (k) @(posedge game_clk);
                tick_pulse();
                if ($urandom_range(0, 1) == 1) begin
                    k = $urandom_range(0, 250);
                    repeat (k) @(posedge game_clk);
                    tick_pulse();
                end
                wait_idle();
            end
        end

        repeat (5) @(posedge game_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
